// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: captures MEM results, aligns and extends load
// data, drives the register-file write port, and exports a forwarding tap and retire statistics.
module mem_wb_stage #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic [2:0]       in_load_type,
    input  logic [4:0]       in_dest_reg,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_rdata,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       write_register,
    output logic [31:0]      write_data,
    output logic             write_enable,
    output logic             fwd_valid,
    output logic [4:0]       fwd_reg,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] retire_count,
    output logic             misalign_err
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic             r_valid;
    logic             r_issued;
    logic             r_reg_write;
    logic             r_mem_to_reg;
    logic [2:0]       r_load_type;
    logic [4:0]       r_dest_reg;
    logic [31:0]      r_alu_result;
    logic [31:0]      r_mem_rdata;
    logic [CNT_W-1:0] r_retire_count;
    logic             r_misalign_err;

    logic             w_capture;
    logic             w_is_half;
    logic             w_is_word;
    logic             w_misaligned;
    logic             w_writes_gpr;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic [31:0]      w_write_data;

    assign w_capture = ~flush & ~stall;

    // issued marks the single cycle right after a capture, so a stalled instruction writes once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_issued     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_load_type  <= 3'b000;
            r_dest_reg   <= 5'd0;
            r_alu_result <= 32'd0;
            r_mem_rdata  <= 32'd0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_issued <= 1'b0;
        end else if (stall) begin
            r_issued <= 1'b0;
        end else begin
            r_valid      <= in_valid;
            r_issued     <= in_valid;
            r_reg_write  <= in_reg_write;
            r_mem_to_reg <= in_mem_to_reg;
            r_load_type  <= in_load_type;
            r_dest_reg   <= in_dest_reg;
            r_alu_result <= in_alu_result;
            r_mem_rdata  <= in_mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else if (w_capture && in_valid) begin
            r_retire_count <= r_retire_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
        end else if (w_misaligned) begin
            r_misalign_err <= 1'b1;
        end
    end

    // Undefined load types 101-111 behave as LW, including the alignment check.
    assign w_is_half = (r_load_type == LT_LH) || (r_load_type == LT_LHU);
    assign w_is_word = !(w_is_half || (r_load_type == LT_LB) || (r_load_type == LT_LBU));

    assign w_misaligned = r_valid & r_mem_to_reg &
                          ((w_is_word & (r_alu_result[1:0] != 2'b00)) |
                           (w_is_half & r_alu_result[0]));

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        if (BIG_ENDIAN) begin
            case (r_alu_result[1:0])
                2'd0:    w_byte = r_mem_rdata[31:24];
                2'd1:    w_byte = r_mem_rdata[23:16];
                2'd2:    w_byte = r_mem_rdata[15:8];
                default: w_byte = r_mem_rdata[7:0];
            endcase
            w_half = r_alu_result[1] ? r_mem_rdata[15:0] : r_mem_rdata[31:16];
        end else begin
            case (r_alu_result[1:0])
                2'd0:    w_byte = r_mem_rdata[7:0];
                2'd1:    w_byte = r_mem_rdata[15:8];
                2'd2:    w_byte = r_mem_rdata[23:16];
                default: w_byte = r_mem_rdata[31:24];
            endcase
            w_half = r_alu_result[1] ? r_mem_rdata[31:16] : r_mem_rdata[15:0];
        end
    end

    always_comb begin
        w_load_data = r_mem_rdata;
        case (r_load_type)
            LT_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  w_load_data = {24'd0, w_byte};
            LT_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = r_mem_rdata;
        endcase
    end

    assign w_write_data = r_mem_to_reg ? w_load_data : r_alu_result;
    assign w_writes_gpr = r_valid & r_reg_write & (r_dest_reg != 5'd0) & ~w_misaligned;

    assign write_register = r_dest_reg;
    assign write_data     = w_write_data;
    assign write_enable   = w_writes_gpr & r_issued;
    assign fwd_valid      = w_writes_gpr;
    assign fwd_reg        = r_dest_reg;
    assign fwd_data       = w_write_data;
    assign retire_count   = r_retire_count;
    assign misalign_err   = r_misalign_err;

endmodule
